data_sram_resp: RTL and testbench

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

---
 rtl/data_sram_resp_pkg.sv | 9 +
 rtl/sram_byte_bank.sv | 32 +++
 rtl/data_sram_resp.sv | 69 ++++++
 tb/tb_data_sram_resp.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_resp_pkg.sv
// Shared constants for the data-side SRAM and the pipeline stages that talk to it.
// The data path is 32 bits wide, split into four byte lanes.
package data_sram_resp_pkg;

   localparam int          DATA_W            = 32;
   localparam int          BYTE_LANES        = 4;
   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1c00_0000;

endpackage

// File: rtl/sram_byte_bank.sv
// One byte lane of the data SRAM: single port, synchronous write, registered read.
// The read register only loads on a read, so it holds its value across writes and idle cycles.
module sram_byte_bank #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [7:0]        wdata,
   output logic [7:0]        rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [7:0] mem [DEPTH];

   // Storage and read register; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[addr] <= wdata;
      end else begin
         mem[addr] <= mem[addr];
      end
      if (rd_en) begin
         rdata <= mem[addr];
      end else begin
         rdata <= rdata;
      end
   end

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM responder: byte-lane writes and one-cycle-latency reads within a mapped window,
// with a one-cycle error pulse for requests that fall outside that window.
module data_sram_resp
   import data_sram_resp_pkg::*;
#(
   parameter int          ADDR_W    = 12,
   parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_we,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic        rdata_valid,
   output logic        addr_err
);

   logic [ADDR_W-1:0] index;
   logic              in_range;
   logic              is_read;
   logic              access;
   logic [DATA_W-1:0] bank_rdata;
   logic              zero_r;
   logic              unused_addr_lsb;

   assign index           = data_sram_addr[ADDR_W+1:2];
   assign in_range        = (data_sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
   assign is_read         = ~|data_sram_we;
   assign access          = resetn & data_sram_en & in_range;
   assign unused_addr_lsb = &{1'b0, data_sram_addr[1:0]};

   genvar lane;
   generate
      for (lane = 0; lane < BYTE_LANES; lane = lane + 1) begin : g_lane
         sram_byte_bank #(
            .ADDR_W (ADDR_W)
         ) u_bank (
            .clk   (clk),
            .wr_en (access & data_sram_we[lane]),
            .rd_en (access & is_read),
            .addr  (index),
            .wdata (data_sram_wdata[8*lane +: 8]),
            .rdata (bank_rdata[8*lane +: 8])
         );
      end
   endgenerate

   // Response flags; zero_r masks the bank output after reset or an out-of-range read.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rdata_valid <= 1'b0;
         addr_err    <= 1'b0;
         zero_r      <= 1'b1;
      end else begin
         rdata_valid <= data_sram_en & is_read;
         addr_err    <= data_sram_en & ~in_range;
         if (data_sram_en & is_read) begin
            zero_r <= ~in_range;
         end else begin
            zero_r <= zero_r;
         end
      end
   end

   assign data_sram_rdata = zero_r ? {DATA_W{1'b0}} : bank_rdata;

endmodule

// File: tb/tb_data_sram_resp.sv
// Scoreboard bench for data_sram_resp: every driven cycle pushes the expected outputs for the
// following cycle, and a negedge monitor pops and compares them.
module tb_data_sram_resp;

   localparam int          ADDR_W = 12;
   localparam int          WORDS  = 1 << ADDR_W;
   localparam logic [31:0] BASE   = 32'h1c00_0000;
   localparam logic [31:0] SPAN   = 32'h0000_4000;

   logic        clk;
   logic        resetn;
   logic        data_sram_en;
   logic [3:0]  data_sram_we;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic        rdata_valid;
   logic        addr_err;

   typedef struct {
      logic        valid;
      logic        err;
      logic [31:0] data;
      logic [31:0] mask;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mem_m   [WORDS];
   logic [3:0]  known_m [WORDS];
   logic [31:0] last_rd;
   logic [31:0] last_mask;
   int          n_cmp;
   int          n_bad;

   data_sram_resp #(
      .ADDR_W    (ADDR_W),
      .BASE_ADDR (BASE)
   ) dut (
      .clk             (clk),
      .resetn          (resetn),
      .data_sram_en    (data_sram_en),
      .data_sram_we    (data_sram_we),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .data_sram_rdata (data_sram_rdata),
      .rdata_valid     (rdata_valid),
      .addr_err        (addr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] lane_mask(input logic [3:0] m);
      logic [31:0] r;
      r = 32'h0;
      for (int i = 0; i < 4; i++) begin
         if (m[i]) r[8*i +: 8] = 8'hff;
      end
      return r;
   endfunction

   // Drive one request, then at the edge record what the next cycle must show.
   task automatic do_cycle(input logic rst_n, input logic en, input logic [3:0] we,
                           input logic [31:0] addr, input logic [31:0] wd);
      exp_t        e;
      int          idx;
      logic        inr;
      logic [31:0] bm;
      resetn          = rst_n;
      data_sram_en    = en;
      data_sram_we    = we;
      data_sram_addr  = addr;
      data_sram_wdata = wd;
      @(posedge clk);
      inr = (addr >= BASE) && (addr < BASE + SPAN);
      idx = int'((addr - BASE) >> 2) % WORDS;
      e.valid = 1'b0;
      e.err   = 1'b0;
      if (!rst_n) begin
         last_rd   = 32'h0;
         last_mask = 32'hffff_ffff;
      end else if (en && !inr) begin
         e.err = 1'b1;
         if (we == 4'h0) begin
            e.valid   = 1'b1;
            last_rd   = 32'h0;
            last_mask = 32'hffff_ffff;
         end
      end else if (en && we == 4'h0) begin
         e.valid   = 1'b1;
         last_rd   = mem_m[idx];
         last_mask = lane_mask(known_m[idx]);
      end else if (en) begin
         bm           = lane_mask(we);
         mem_m[idx]   = (mem_m[idx] & ~bm) | (wd & bm);
         known_m[idx] = known_m[idx] | we;
      end
      e.data = last_rd;
      e.mask = last_mask;
      exp_q.push_back(e);
      #1;
   endtask

   function automatic logic [31:0] rand_in_addr();
      logic [31:0] idx;
      case ($urandom_range(0, 3))
         0:       idx = 32'd0;
         1:       idx = WORDS - 1;
         default: idx = $urandom_range(0, 31);
      endcase
      return BASE + (idx << 2) + $urandom_range(0, 3);
   endfunction

   // Monitor: compare DUT outputs against the oldest expectation each cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (rdata_valid !== e.valid || addr_err !== e.err ||
                ((data_sram_rdata & e.mask) !== (e.data & e.mask))) begin
               n_bad++;
               $display("FAIL resp@%0t: got valid=%b err=%b rdata=%h, want valid=%b err=%b rdata=%h (mask %h)",
                        $time, rdata_valid, addr_err, data_sram_rdata, e.valid, e.err, e.data, e.mask);
            end
         end
      end
   end

   initial begin
      logic [31:0] a;
      int          wait_cnt;
      n_cmp     = 0;
      n_bad     = 0;
      last_rd   = 32'h0;
      last_mask = 32'hffff_ffff;
      for (int i = 0; i < WORDS; i++) begin
         mem_m[i]   = 32'h0;
         known_m[i] = 4'h0;
      end

      do_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      do_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

      // Full-word write then immediate read, then idle hold.
      do_cycle(1'b1, 1'b1, 4'hf, 32'h1c00_0010, 32'hdead_beef);
      do_cycle(1'b1, 1'b1, 4'h0, 32'h1c00_0010, 32'h0);
      do_cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
      do_cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);

      // Single-lane merge.
      do_cycle(1'b1, 1'b1, 4'hf, 32'h1c00_0020, 32'h1122_3344);
      do_cycle(1'b1, 1'b1, 4'b0100, 32'h1c00_0020, 32'h00aa_0000);
      do_cycle(1'b1, 1'b1, 4'h0, 32'h1c00_0020, 32'h0);
      do_cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);

      // First and last legal words, read back-to-back.
      do_cycle(1'b1, 1'b1, 4'hf, 32'h1c00_0000, 32'h0bad_f00d);
      do_cycle(1'b1, 1'b1, 4'hf, 32'h1c00_3ffc, 32'hcafe_1234);
      do_cycle(1'b1, 1'b1, 4'h0, 32'h1c00_0000, 32'h0);
      do_cycle(1'b1, 1'b1, 4'h0, 32'h1c00_3ffc, 32'h0);
      do_cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
      do_cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);

      // Just past the window and just below it; word 0 must survive.
      do_cycle(1'b1, 1'b1, 4'hf, 32'h1c00_4000, 32'h5555_aaaa);
      do_cycle(1'b1, 1'b1, 4'h0, 32'h1c00_4000, 32'h0);
      do_cycle(1'b1, 1'b1, 4'h0, 32'h1bff_fffc, 32'h0);
      do_cycle(1'b1, 1'b1, 4'h0, 32'h1c00_0000, 32'h0);
      do_cycle(1'b1, 1'b1, 4'h0, 32'h1c00_4000, 32'h0);
      do_cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);

      // Reset right after a read; a write presented during reset is dropped.
      do_cycle(1'b1, 1'b1, 4'h0, 32'h1c00_0010, 32'h0);
      do_cycle(1'b0, 1'b1, 4'hf, 32'h1c00_0010, 32'h7777_7777);
      do_cycle(1'b0, 1'b1, 4'h0, 32'h1c00_0010, 32'h0);
      do_cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
      do_cycle(1'b1, 1'b1, 4'h0, 32'h1c00_0010, 32'h0);
      do_cycle(1'b1, 1'b1, 4'h0, 32'h1c00_3ffc, 32'h0);

      // Idle with write enables and random address/data must not disturb anything.
      for (int i = 0; i < 100; i++) begin
         a = $urandom();
         if (i % 2 == 0) a = rand_in_addr();
         do_cycle(1'b1, 1'b0, 4'hf, a, $urandom());
      end
      do_cycle(1'b1, 1'b1, 4'h0, 32'h1c00_0000, 32'h0);
      do_cycle(1'b1, 1'b1, 4'h0, 32'h1c00_0010, 32'h0);
      do_cycle(1'b1, 1'b1, 4'h0, 32'h1c00_0020, 32'h0);
      do_cycle(1'b1, 1'b1, 4'h0, 32'h1c00_3ffc, 32'h0);

      // Random mix of reads, partial writes, idles, misses and occasional resets.
      for (int i = 0; i < 600; i++) begin
         logic        r_n;
         logic        en;
         logic [3:0]  we;
         r_n = ($urandom_range(0, 49) != 0);
         en  = ($urandom_range(0, 4) != 0);
         we  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         a   = rand_in_addr();
         if ($urandom_range(0, 9) == 0) a = BASE + SPAN + $urandom_range(0, 32'hffff);
         if ($urandom_range(0, 19) == 0) a = BASE - 32'd4 - $urandom_range(0, 32'hff);
         do_cycle(r_n, en, we, a, $urandom());
      end

      do_cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
      do_cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
      wait_cnt = 0;
      while (exp_q.size() > 0 && wait_cnt < 10) begin
         @(negedge clk);
         wait_cnt++;
      end
      #1;
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
